// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters,
// holding registered operands for ALU_LAT cycles and returning the result on a response channel.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req0_alu_op,
    input  logic [1:0]       req1_alu_op,
    input  logic [3:0]       req0_opcode,
    input  logic [3:0]       req1_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       alu_op_o,
    output logic [3:0]       alu_opcode_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
    logic [1:0]       state_q, state_d;
    logic             last_q, last_d, owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d, rsp_valid_q, rsp_valid_d;
    logic [3:0]       opc_q, opc_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             gnt, accept;
    // On a tie the requester that did not win last time is granted
    assign gnt       = (req_valid == 2'b10) | ((req_valid == 2'b11) & ~last_q);
    assign req_ready = (state_q == IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = |req_ready;
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        opc_d       = opc_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        res_d       = res_q;
        if (state_q == IDLE && accept) begin
            op_d    = gnt ? req1_alu_op : req0_alu_op;
            opc_d   = gnt ? req1_opcode : req0_opcode;
            a_d     = gnt ? req1_a : req0_a;
            b_d     = gnt ? req1_b : req0_b;
            owner_d = gnt;
            last_d  = gnt;
            cnt_d   = 4'(ALU_LAT - 1);
            state_d = EXEC;
        end else if (state_q == EXEC) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                res_d       = alu_result_i;
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
        end else if (state_q == RESP && rsp_ready[owner_q]) begin
            rsp_valid_d = 2'b00;
            state_d     = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            cnt_q       <= 4'd0;
            op_q        <= 2'd0;
            opc_q       <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 2'b00;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            opc_q       <= opc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            res_q       <= res_d;
        end
    end
    assign alu_op_o     = op_q;
    assign alu_opcode_o = opc_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = res_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a response scoreboard; a second instance covers ALU_LAT=3.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp); end end
module tb_alu_share_arbiter;
    typedef struct packed {logic [1:0] oh; logic [31:0] res;} exp_t;
    logic        clk, rst;
    logic [1:0]  rv, rr, rv3, rr3;
    logic [1:0]  r0op, r1op;
    logic [3:0]  r0opc, r1opc;
    logic [31:0] r0a, r0b, r1a, r1b;
    logic [1:0]  req_ready, rsp_valid, alu_op, req_ready3, rsp_valid3, alu_op3;
    logic [3:0]  alu_opc, alu_opc3;
    logic [31:0] alu_a, alu_b, alu_res, rsp_result, alu_a3, alu_b3, alu_res3, rsp_result3;
    logic        busy, busy3;
    int          errors = 0, checks = 0;
    exp_t        sb[$];
    exp_t        e;
    function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        return (op == 2'b01 || (op == 2'b10 && opc == 4'b0001)) ? a - b : a + b;
    endfunction
    assign alu_res  = alu_model(alu_op, alu_opc, alu_a, alu_b);
    assign alu_res3 = alu_model(alu_op3, alu_opc3, alu_a3, alu_b3);
    alu_share_arbiter #(.WIDTH(32), .ALU_LAT(1)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv), .req_ready(req_ready),
        .req0_alu_op(r0op), .req1_alu_op(r1op), .req0_opcode(r0opc), .req1_opcode(r1opc),
        .req0_a(r0a), .req0_b(r0b), .req1_a(r1a), .req1_b(r1b),
        .alu_op_o(alu_op), .alu_opcode_o(alu_opc), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_result_i(alu_res), .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_result(rsp_result), .busy(busy));
    alu_share_arbiter #(.WIDTH(32), .ALU_LAT(3)) u3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(req_ready3),
        .req0_alu_op(r0op), .req1_alu_op(r1op), .req0_opcode(r0opc), .req1_opcode(r1opc),
        .req0_a(r0a), .req0_b(r0b), .req1_a(r1a), .req1_b(r1b),
        .alu_op_o(alu_op3), .alu_opcode_o(alu_opc3), .alu_a_o(alu_a3), .alu_b_o(alu_b3),
        .alu_result_i(alu_res3), .rsp_valid(rsp_valid3), .rsp_ready(rr3), .rsp_result(rsp_result3), .busy(busy3));
    always #5 clk = ~clk;
    // Responses are retired from the scoreboard on the handshake, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && |(rsp_valid & rr)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty: observed=%0h expected=none", rsp_valid);
            end else begin
                e = sb.pop_front();
                `CHK("rsp_owner", rsp_valid, e.oh)
                `CHK("rsp_result", rsp_result, e.res)
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drain();
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        `CHK("drain", sb.size(), 0)
    endtask
    initial begin
        clk = 0; rst = 1; rv = 0; rr = 0; rv3 = 0; rr3 = 0;
        r0op = 0; r1op = 0; r0opc = 0; r1opc = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0;
        repeat (2) tick();
        `CHK("rst_req_ready", req_ready, 2'b00)
        `CHK("rst_rsp_valid", rsp_valid, 2'b00)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_alu_a", alu_a, 32'd0)
        `CHK("rst_rsp_result", rsp_result, 32'd0)
        rst = 0;
        tick();
        // single op from requester 0, ALU_LAT=1
        rv = 2'b01; r0op = 2'b10; r0opc = 4'b0000; r0a = 5; r0b = 7;
        #1;
        `CHK("t1_ready", req_ready, 2'b01)
        sb.push_back('{2'b01, 32'd12});
        tick();
        rv = 0; rr = 2'b01;
        `CHK("t1_alu_a", alu_a, 32'd5)
        `CHK("t1_alu_b", alu_b, 32'd7)
        `CHK("t1_alu_op", alu_op, 2'b10)
        `CHK("t1_busy", busy, 1'b1)
        `CHK("t1_ready_exec", req_ready, 2'b00)
        tick();
        `CHK("t1_rsp_valid", rsp_valid, 2'b01)
        `CHK("t1_rsp_result", rsp_result, 32'd12)
        tick();
        `CHK("t1_idle", busy, 1'b0)
        // fairness: last grant was 0, so contention alternates starting with 1
        begin
            int n, last_c;
            logic [1:0] exp_oh;
            n = 0; last_c = 0;
            r0op = 2'b00; r0opc = 4'b0000; r0a = 100; r0b = 1;
            r1op = 2'b10; r1opc = 4'b0001; r1a = 50; r1b = 8;
            rr = 2'b11; rv = 2'b11;
            #1;
            for (int c = 0; c < 40 && n < 4; c++) begin
                if (|req_ready) begin
                    exp_oh = (n % 2 == 0) ? 2'b10 : 2'b01;
                    `CHK("rr_grant", req_ready, exp_oh)
                    if (n > 0) `CHK("rr_interval", c - last_c, 3)
                    last_c = c;
                    sb.push_back('{exp_oh, exp_oh[1] ? 32'd42 : 32'd101});
                    n++;
                end
                tick();
            end
            rv = 0;
            `CHK("rr_count", n, 4)
            drain();
        end
        // response held while rsp_ready is low; non-owner ready ignored
        rr = 0; rv = 2'b10; r1op = 2'b10; r1opc = 4'b0000; r1a = 3; r1b = 4;
        #1;
        `CHK("t3_ready", req_ready, 2'b10)
        sb.push_back('{2'b10, 32'd7});
        tick();
        rv = 2'b11;
        tick();
        `CHK("t3_rsp_valid", rsp_valid, 2'b10)
        for (int i = 0; i < 5; i++) begin
            `CHK("t3_hold_valid", rsp_valid, 2'b10)
            `CHK("t3_hold_result", rsp_result, 32'd7)
            `CHK("t3_hold_ready", req_ready, 2'b00)
            tick();
        end
        rr = 2'b01;
        tick();
        `CHK("t6_wrong_ready_valid", rsp_valid, 2'b10)
        `CHK("t6_wrong_ready_busy", busy, 1'b1)
        rv = 0; rr = 2'b10;
        tick();
        `CHK("t3_release_busy", busy, 1'b0)
        `CHK("t3_release_valid", rsp_valid, 2'b00)
        `CHK("t3_sb", sb.size(), 0)
        // ALU_LAT=3 instance
        rv3 = 2'b10; r1op = 2'b01; r1opc = 4'b1111; r1a = 9; r1b = 9; rr3 = 0;
        #1;
        `CHK("t4_ready", req_ready3, 2'b10)
        tick();
        rv3 = 0;
        for (int i = 0; i < 3; i++) begin
            `CHK("t4_hold_a", alu_a3, 32'd9)
            `CHK("t4_hold_b", alu_b3, 32'd9)
            `CHK("t4_hold_op", alu_op3, 2'b01)
            `CHK("t4_no_rsp", rsp_valid3, 2'b00)
            tick();
        end
        `CHK("t4_rsp_valid", rsp_valid3, 2'b10)
        `CHK("t4_rsp_result", rsp_result3, 32'd0)
        rr3 = 2'b10;
        tick();
        `CHK("t4_idle", busy3, 1'b0)
        // reset during EXEC drops the operation
        rr = 2'b11; rv = 2'b01; r0op = 2'b00; r0opc = 4'b0000; r0a = 1; r0b = 2;
        #1;
        `CHK("t5_ready", req_ready, 2'b01)
        sb.push_back('{2'b01, 32'd3});
        tick();
        rv = 0;
        `CHK("t5_busy_exec", busy, 1'b1)
        rst = 1;
        #1;
        void'(sb.pop_back());
        `CHK("t5_rst_busy", busy, 1'b0)
        `CHK("t5_rst_rsp_valid", rsp_valid, 2'b00)
        `CHK("t5_rst_alu_a", alu_a, 32'd0)
        `CHK("t5_rst_alu_op", alu_op, 2'b00)
        tick();
        rst = 0;
        tick();
        rv = 2'b11;
        #1;
        `CHK("t5_tie_after_rst", req_ready, 2'b01)
        sb.push_back('{2'b01, 32'd3});
        tick();
        rv = 0;
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
